// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the instruction memory.
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;
    localparam int HDR_W       = 8;

    typedef enum logic [1:0] {
        WAIT_HDR,
        LOAD,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four stream bytes, most significant first, into one 32-bit word.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             accept_i,
    input  logic [HDR_W-1:0] byte_i,
    output logic [31:0]      word_o,
    output logic             done_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clr_i) begin
            idx_d = 2'd0;
        end else if (accept_i) begin
            shift_d = {shift_q[15:0], byte_i};
            idx_d   = idx_q + 2'd1;
        end
    end

    // The fourth byte is combined directly, so the word is ready in its accept cycle.
    assign word_o = {shift_q, byte_i};
    assign done_o = accept_i && (idx_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_q <= 2'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header byte N, then N big-endian words written to consecutive imem addresses.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [HDR_W-1:0]  In_Byte,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic              Restart,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [31:0]       Wr_Data,
    output logic [ADDR_W:0]   Words_Loaded,
    output logic              Done,
    output logic              Error,
    output logic              Cpu_Rst
);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                done_q, done_d;

    logic                hdr_take;
    logic                load_take;
    logic                hdr_ok;
    logic                word_done;
    logic [31:0]         word;

    assign In_Ready  = (state_q == WAIT_HDR) || (state_q == LOAD);
    assign hdr_take  = In_Valid && (state_q == WAIT_HDR);
    assign load_take = In_Valid && (state_q == LOAD);
    assign hdr_ok    = (In_Byte != '0) && (int'(In_Byte) <= DEPTH);

    imem_word_assembler u_asm (
        .clk_i    (Clk),
        .rst_ni   (Rst),
        .clr_i    (hdr_take),
        .accept_i (load_take),
        .byte_i   (In_Byte),
        .word_o   (word),
        .done_o   (word_done)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        words_d   = words_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        case (state_q)
            WAIT_HDR: begin
                if (hdr_take) begin
                    if (hdr_ok) begin
                        count_d   = In_Byte[ADDR_W:0];
                        words_d   = '0;
                        wr_addr_d = '0;
                        state_d   = LOAD;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            LOAD: begin
                if (word_done) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = word;
                    wr_addr_d = words_q[ADDR_W-1:0];
                    words_d   = words_q + 1'b1;
                    // Leaving LOAD together with the last strobe drops In_Ready immediately.
                    if ((words_q + 1'b1) == count_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (Restart) begin
                    state_d = WAIT_HDR;
                    words_d = '0;
                end else begin
                    done_d = 1'b1;
                end
            end
            ERROR: begin
                if (Restart) begin
                    state_d = WAIT_HDR;
                    words_d = '0;
                end
            end
            default: state_d = WAIT_HDR;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= WAIT_HDR;
            count_q   <= '0;
            words_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            words_q   <= words_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign Wr_En        = wr_en_q;
    assign Wr_Addr      = wr_addr_q;
    assign Wr_Data      = wr_data_q;
    assign Words_Loaded = words_q;
    assign Done         = done_q;
    assign Cpu_Rst      = done_q;
    assign Error        = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios, hand-written corner sequences and random loads.
module tb_imem_loader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [7:0]  In_Byte = 8'h00;
    logic        In_Valid = 1'b0;
    logic        Restart = 1'b0;
    logic        In_Ready;
    logic        Wr_En;
    logic [5:0]  Wr_Addr;
    logic [31:0] Wr_Data;
    logic [6:0]  Words_Loaded;
    logic        Done;
    logic        Error;
    logic        Cpu_Rst;

    imem_loader dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .In_Byte      (In_Byte),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .Restart      (Restart),
        .Wr_En        (Wr_En),
        .Wr_Addr      (Wr_Addr),
        .Wr_Data      (Wr_Data),
        .Words_Loaded (Words_Loaded),
        .Done         (Done),
        .Error        (Error),
        .Cpu_Rst      (Cpu_Rst)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  hdr;
        int          pat;
        int          gap;
        bit          err;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t       vecs [7];
    logic [7:0] fixed_b [8];
    wr_t        act_q [$];
    logic [7:0] bq [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_wr_cyc = -100;
    int         done_rise_cyc = -200;
    logic       done_prev = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Wr_En) begin
            act_q.push_back('{Wr_Addr, Wr_Data});
            last_wr_cyc = cyc;
        end
        if (Done && !done_prev) done_rise_cyc = cyc;
        done_prev = Done;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] gen_byte(input int pat, input int idx);
        logic [31:0] w;
        if (pat == 0) return fixed_b[idx];
        if (pat == 1) begin
            w = (32'h1000_0000 + 32'(idx / 4)) >> (8 * (3 - (idx % 4)));
            return w[7:0];
        end
        w = $urandom;
        return w[7:0];
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        int tries;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        In_Valid = 1'b0;
        repeat (g) tick();
        In_Byte  = b;
        In_Valid = 1'b1;
        tries    = 0;
        while (!In_Ready && tries < 20) begin
            tick();
            tries++;
        end
        if (!In_Ready) chk("in_ready_wait", 32'(In_Ready), 32'd1);
        tick();
        In_Valid = 1'b0;
    endtask

    task automatic do_restart();
        Restart = 1'b1;
        tick();
        Restart = 1'b0;
        chk("restart_in_ready", 32'(In_Ready), 32'd1);
        chk("restart_done", 32'(Done), 32'd0);
        chk("restart_cpu_rst", 32'(Cpu_Rst), 32'd0);
        chk("restart_error", 32'(Error), 32'd0);
        chk("restart_words", 32'(Words_Loaded), 32'd0);
    endtask

    task automatic run_load(input logic [7:0] hdr, input int pat, input int gap,
                            input bit check_ends, input logic [31:0] first, input logic [31:0] last);
        int n;
        int t;
        logic [7:0]  b;
        logic [31:0] w;
        bq.delete();
        act_q.delete();
        last_wr_cyc   = -100;
        done_rise_cyc = -200;
        n = int'(hdr);
        send_byte(hdr, gap);
        if (n == 0 || n > 64) begin
            tick();
            tick();
            chk("err_flag", 32'(Error), 32'd1);
            chk("err_in_ready", 32'(In_Ready), 32'd0);
            chk("err_cpu_rst", 32'(Cpu_Rst), 32'd0);
            chk("err_done", 32'(Done), 32'd0);
            chk("err_no_writes", 32'(act_q.size()), 32'd0);
        end else begin
            for (int i = 0; i < 4 * n; i++) begin
                b = gen_byte(pat, i);
                bq.push_back(b);
                send_byte(b, gap);
            end
            t = 0;
            while (!Done && t < 20) begin
                tick();
                t++;
            end
            repeat (3) tick();
            chk("done", 32'(Done), 32'd1);
            chk("cpu_rst", 32'(Cpu_Rst), 32'd1);
            chk("error_clear", 32'(Error), 32'd0);
            chk("done_in_ready", 32'(In_Ready), 32'd0);
            chk("words_loaded", 32'(Words_Loaded), 32'(n));
            chk("write_count", 32'(act_q.size()), 32'(n));
            chk("done_latency", 32'(done_rise_cyc - last_wr_cyc), 32'd1);
            for (int i = 0; i < act_q.size() && i < n; i++) begin
                w = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
                chk("wr_addr", 32'(act_q[i].addr), 32'(i));
                chk("wr_data", act_q[i].data, w);
            end
            if (check_ends && act_q.size() == n) begin
                chk("first_word", act_q[0].data, first);
                chk("last_word", act_q[n-1].data, last);
            end
        end
    endtask

    initial begin
        logic [7:0]  hdr;
        logic [7:0]  b;
        logic [31:0] w;

        fixed_b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
        vecs[0] = '{8'h02, 0, 0, 1'b0, 32'h2008_0005, 32'h8C09_0000};
        vecs[1] = '{8'h02, 0, 3, 1'b0, 32'h2008_0005, 32'h8C09_0000};
        vecs[2] = '{8'h00, 0, 0, 1'b1, 32'h0, 32'h0};
        vecs[3] = '{8'h41, 0, 0, 1'b1, 32'h0, 32'h0};
        vecs[4] = '{8'h40, 1, 0, 1'b0, 32'h1000_0000, 32'h1000_003F};
        vecs[5] = '{8'h01, 1, 1, 1'b0, 32'h1000_0000, 32'h1000_0000};
        vecs[6] = '{8'hFF, 0, 0, 1'b1, 32'h0, 32'h0};

        Rst = 1'b0;
        repeat (3) tick();
        chk("rst_wr_en", 32'(Wr_En), 32'd0);
        chk("rst_wr_addr", 32'(Wr_Addr), 32'd0);
        chk("rst_wr_data", Wr_Data, 32'd0);
        chk("rst_words", 32'(Words_Loaded), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        chk("rst_cpu_rst", 32'(Cpu_Rst), 32'd0);
        chk("rst_in_ready", 32'(In_Ready), 32'd1);
        Rst = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            if (v > 0) do_restart();
            run_load(vecs[v].hdr, vecs[v].pat, vecs[v].gap, !vecs[v].err, vecs[v].first, vecs[v].last);
        end

        // Restart and a valid byte together while DONE: the byte must be dropped.
        do_restart();
        run_load(8'h01, 2, 0, 1'b0, 32'h0, 32'h0);
        In_Byte  = 8'h01;
        In_Valid = 1'b1;
        Restart  = 1'b1;
        tick();
        Restart  = 1'b0;
        In_Valid = 1'b0;
        chk("sim_in_ready", 32'(In_Ready), 32'd1);
        chk("sim_done", 32'(Done), 32'd0);
        chk("sim_cpu_rst", 32'(Cpu_Rst), 32'd0);
        chk("sim_words", 32'(Words_Loaded), 32'd0);
        run_load(8'h02, 2, 0, 1'b0, 32'h0, 32'h0);

        for (int k = 0; k < 20; k++) begin
            do_restart();
            if ($urandom_range(0, 7) == 0)
                hdr = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255));
            else
                hdr = 8'($urandom_range(1, 12));
            run_load(hdr, 2, -1, 1'b0, 32'h0, 32'h0);
        end

        // Reset in the middle of the second word of a two-word load.
        do_restart();
        act_q.delete();
        bq.delete();
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            bq.push_back(b);
            send_byte(b, 0);
        end
        tick();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        chk("mid_write_count", 32'(act_q.size()), 32'd1);
        if (act_q.size() >= 1) begin
            w = {bq[0], bq[1], bq[2], bq[3]};
            chk("mid_wr_addr", 32'(act_q[0].addr), 32'd0);
            chk("mid_wr_data", act_q[0].data, w);
        end
        chk("mid_rst_wr_en", 32'(Wr_En), 32'd0);
        chk("mid_rst_wr_addr", 32'(Wr_Addr), 32'd0);
        chk("mid_rst_wr_data", Wr_Data, 32'd0);
        chk("mid_rst_words", 32'(Words_Loaded), 32'd0);
        chk("mid_rst_done", 32'(Done), 32'd0);
        chk("mid_rst_error", 32'(Error), 32'd0);
        chk("mid_rst_cpu_rst", 32'(Cpu_Rst), 32'd0);
        chk("mid_rst_in_ready", 32'(In_Ready), 32'd1);
        repeat (4) tick();
        chk("mid_no_extra_write", 32'(act_q.size()), 32'd1);
        run_load(8'h01, 2, 0, 1'b0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
